// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit accumulator CPU: opcodes, reset vector and
// the memory-reference classification used for indirect addressing.
package cpu_pkg;

    localparam logic [15:0] RESET_PC = 16'h0100;

    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_NOT   = 4'h7;
    localparam logic [3:0] OP_BACK  = 4'h8;
    localparam logic [3:0] OP_SKIP  = 4'h9;
    localparam logic [3:0] OP_JUMP  = 4'hA;
    localparam logic [3:0] OP_CLEAR = 4'hB;
    localparam logic [3:0] OP_MUL   = 4'hC;
    localparam logic [3:0] OP_HALT  = 4'hF;

    // Only these opcodes carry an operand address whose bit 11 selects indirection.
    function automatic logic is_mem_ref(input logic [3:0] opcode);
        logic r;
        r = 1'b0;
        case (opcode)
            OP_LOAD, OP_STORE, OP_ADD, OP_SUB,
            OP_AND, OP_OR, OP_NOT, OP_MUL: r = 1'b1;
            default:                       r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: RAM port, issue handshake to execute, PC redirect.
// Handshake: an instruction transfers on any rising edge where ir_valid && ir_ready;
// ir_out/ir_pc/ir_valid stay stable while ir_valid=1 and ir_ready=0.
interface fetch_unit_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_cs;
    logic                  mem_we;
    logic                  mem_oe;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  bus_busy;
    logic [15:0]           ir_out;
    logic [15:0]           ir_pc;
    logic                  ir_valid;
    logic                  ir_ready;
    logic                  redirect_valid;
    logic [15:0]           redirect_pc;
    logic                  halted;

    modport master (
        output mem_addr, mem_cs, mem_we, mem_oe, bus_busy,
        output ir_out, ir_pc, ir_valid, halted,
        input  mem_rdata, ir_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  mem_addr, mem_cs, mem_we, mem_oe, bus_busy,
        input  ir_out, ir_pc, ir_valid, halted,
        output mem_rdata, ir_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns PC, reads the instruction word, resolves one
// level of indirection for memory-reference opcodes and issues to execute.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int          ADDR_WIDTH = 15,
    parameter int          DATA_WIDTH = 16,
    parameter int          RD_LAT     = 2,
    parameter logic [15:0] RESET_PC_P = RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_unit_if.master      bus,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        START  = 3'd0,
        FWAIT  = 3'd1,
        DECODE = 3'd2,
        IWAIT  = 3'd3,
        ISSUE  = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

    state_t                state_q, state_d;
    logic [15:0]           pc_q, pc_d;
    logic [15:0]           ir_q, ir_d;
    logic [15:0]           ir_out_q, ir_out_d;
    logic [15:0]           ir_pc_q, ir_pc_d;
    logic                  valid_q, valid_d;
    logic                  halted_q, halted_d;
    logic                  busy_q, busy_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rd_q, rd_d;
    logic [2:0]            lat_q, lat_d;
    logic                  launch;
    logic [15:0]           launch_pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= START;
            pc_q     <= RESET_PC_P;
            ir_q     <= '0;
            ir_out_q <= '0;
            ir_pc_q  <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            busy_q   <= 1'b0;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            lat_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            ir_out_q <= ir_out_d;
            ir_pc_q  <= ir_pc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            busy_q   <= busy_d;
            addr_q   <= addr_d;
            rd_q     <= rd_d;
            lat_q    <= lat_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        ir_out_d  = ir_out_q;
        ir_pc_d   = ir_pc_q;
        valid_d   = valid_q;
        halted_d  = halted_q;
        busy_d    = busy_q;
        addr_d    = addr_q;
        rd_d      = rd_q;
        lat_d     = lat_q;
        launch    = 1'b0;
        launch_pc = pc_q;

        case (state_q)
            START: launch = 1'b1;
            FWAIT: begin
                if (lat_q == LAT_LAST) begin
                    ir_d    = bus.mem_rdata;
                    ir_pc_d = pc_q;
                    pc_d    = pc_q + 16'd1;
                    rd_d    = 1'b0;
                    state_d = DECODE;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            DECODE: begin
                if (ir_q[11] && is_mem_ref(ir_q[15:12])) begin
                    addr_d  = ADDR_WIDTH'(ir_q[11:0]);
                    rd_d    = 1'b1;
                    lat_d   = '0;
                    state_d = IWAIT;
                end else begin
                    ir_out_d = ir_q;
                    valid_d  = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ISSUE;
                end
            end
            IWAIT: begin
                if (lat_q == LAT_LAST) begin
                    // Single level only: the pointer's own bit 11 is ignored.
                    ir_out_d = {ir_q[15:12], bus.mem_rdata[11:0]};
                    rd_d     = 1'b0;
                    valid_d  = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ISSUE;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            ISSUE: begin
                if (valid_q && bus.ir_ready) begin
                    valid_d = 1'b0;
                    if (ir_out_q[15:12] == OP_HALT) begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                    end else begin
                        launch = 1'b1;
                    end
                end
            end
            HALT: ;
            default: state_d = START;
        endcase

        // Redirect beats everything but reset; any in-flight capture is discarded.
        if (bus.redirect_valid && state_q != HALT) begin
            launch    = 1'b1;
            launch_pc = bus.redirect_pc;
            pc_d      = bus.redirect_pc;
            ir_d      = ir_q;
            ir_pc_d   = ir_pc_q;
            valid_d   = 1'b0;
            halted_d  = halted_q;
        end

        if (launch) begin
            addr_d  = launch_pc[ADDR_WIDTH-1:0];
            rd_d    = 1'b1;
            busy_d  = 1'b1;
            lat_d   = '0;
            state_d = FWAIT;
        end
    end

    assign bus.mem_addr = addr_q;
    assign bus.mem_cs   = rd_q;
    assign bus.mem_oe   = rd_q;
    assign bus.mem_we   = 1'b0;
    assign bus.bus_busy = busy_q;
    assign bus.ir_out   = ir_out_q;
    assign bus.ir_pc    = ir_pc_q;
    assign bus.ir_valid = valid_q;
    assign bus.halted   = halted_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: RAM model with two-edge read latency,
// directed fetch sequence and a scoreboard of issued {ir_out, ir_pc} pairs.
module tb_fetch_unit;

    localparam int AW = 15;
    localparam logic [2:0] ST_START = 3'd0;
    localparam logic [2:0] ST_HALT  = 3'd5;

    logic       clk;
    logic       rst_n;
    logic [2:0] dbg_state;

    fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(16)) bus ();

    fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(16), .RD_LAT(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.master),
        .dbg_state (dbg_state)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    logic [31:0] exp_q[$];
    logic [15:0] mem [0:(1<<AW)-1];
    logic [15:0] rdata_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered RAM output: data addressed at edge E0 is sampled by the DUT at E0+2.
    always @(posedge clk) rdata_q <= (bus.mem_cs && bus.mem_oe) ? mem[bus.mem_addr] : 16'hDEAD;
    assign bus.mem_rdata = rdata_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.ir_valid && bus.ir_ready) begin
            if (exp_q.size() == 0) check("sb_unexpected", {bus.ir_out, bus.ir_pc}, 32'h0);
            else check("sb_issue", {bus.ir_out, bus.ir_pc}, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.ir_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    int  n;
    logic ok;

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 16'hEEEE;
        mem[15'h100] = 16'h110C;
        mem[15'h101] = 16'h3900;
        mem[15'h900] = 16'h010B;
        mem[15'h102] = 16'h9800;
        mem[15'h103] = 16'h1234;
        mem[15'h104] = 16'hF000;
        rst_n = 1'b0;
        bus.ir_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 16'h0;

        tick();
        check("rst_addr", 32'(bus.mem_addr), 32'h0);
        check("rst_cs_oe_we", {29'h0, bus.mem_cs, bus.mem_oe, bus.mem_we}, 32'h0);
        check("rst_valid_halt_busy", {29'h0, bus.ir_valid, bus.halted, bus.bus_busy}, 32'h0);
        check("rst_ir", {bus.ir_out, bus.ir_pc}, 32'h0);
        check("rst_state", 32'(dbg_state), 32'(ST_START));

        // Direct fetch
        rst_n = 1'b1;
        bus.ir_ready = 1'b1;
        exp_q.push_back({16'h110C, 16'h0100});
        tick();
        check("t1_launch", {15'h0, bus.mem_addr, bus.mem_cs, bus.mem_oe}, {15'h0, 15'h100, 2'b11});
        check("t1_busy", 32'(bus.bus_busy), 32'h1);
        wait_valid(n);
        check("t1_lat", 32'(n), 32'd3);
        check("t1_ir", {bus.ir_out, bus.ir_pc}, {16'h110C, 16'h0100});

        // Indirect fetch
        exp_q.push_back({16'h310B, 16'h0101});
        tick();
        check("t2_launch", {16'h0, bus.mem_addr, bus.mem_cs}, {16'h0, 15'h101, 1'b1});
        repeat (3) tick();
        check("t2_ind_addr", {16'h0, bus.mem_addr, bus.mem_cs}, {16'h0, 15'h900, 1'b1});
        check("t2_ind_valid", 32'(bus.ir_valid), 32'h0);
        repeat (2) tick();
        check("t2_valid_e5", 32'(bus.ir_valid), 32'h1);
        check("t2_ir", {bus.ir_out, bus.ir_pc}, {16'h310B, 16'h0101});

        // Skip passthrough, no second read
        exp_q.push_back({16'h9800, 16'h0102});
        tick();
        check("t3_launch", 32'(bus.mem_addr), 32'h102);
        repeat (3) tick();
        check("t3_ir", {bus.ir_out, bus.ir_pc}, {16'h9800, 16'h0102});
        check("t3_no_ind", {29'h0, bus.ir_valid, bus.mem_cs, bus.bus_busy}, 32'h4);

        // Redirect during FWAIT of 103
        tick();
        check("t5_launch103", 32'(bus.mem_addr), 32'h103);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'h0100;
        tick();
        bus.redirect_valid = 1'b0;
        bus.ir_ready = 1'b0;
        check("t5_redirect", {15'h0, bus.mem_addr, bus.mem_cs, bus.ir_valid}, {15'h0, 15'h100, 2'b10});
        exp_q.push_back({16'h110C, 16'h0100});
        wait_valid(n);
        check("t5_lat", 32'(n), 32'd3);
        check("t5_ir", {bus.ir_out, bus.ir_pc}, {16'h110C, 16'h0100});

        // Backpressure
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.ir_valid !== 1'b1 || bus.ir_out !== 16'h110C || bus.ir_pc !== 16'h0100 ||
                bus.mem_cs !== 1'b0 || bus.bus_busy !== 1'b0) ok = 1'b0;
        end
        check("t4_hold", 32'(ok), 32'h1);
        bus.ir_ready = 1'b1;
        exp_q.push_back({16'h310B, 16'h0101});
        tick();
        check("t4_release", {15'h0, bus.mem_addr, bus.mem_cs, bus.ir_valid}, {15'h0, 15'h101, 2'b10});
        wait_valid(n);
        check("t4_ind_lat", 32'(n), 32'd5);

        // Redirect together with handshake: 9800 consumed, fetch goes to 104
        exp_q.push_back({16'h9800, 16'h0102});
        tick();
        wait_valid(n);
        check("t6_lat", 32'(n), 32'd3);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'h0104;
        exp_q.push_back({16'hF000, 16'h0104});
        tick();
        bus.redirect_valid = 1'b0;
        check("t6_redir_hs", {16'h0, bus.mem_addr, bus.mem_cs}, {16'h0, 15'h104, 1'b1});
        wait_valid(n);
        check("t6_halt_ir", {bus.ir_out, bus.ir_pc}, {16'hF000, 16'h0104});

        // Halt absorbs, redirect ignored
        tick();
        check("t6_halted", {29'h0, bus.halted, bus.ir_valid, bus.mem_cs}, 32'h4);
        check("t6_state", 32'(dbg_state), 32'(ST_HALT));
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.redirect_valid = (i == 5);
            tick();
            if (bus.mem_cs !== 1'b0 || bus.halted !== 1'b1 || bus.ir_valid !== 1'b0 ||
                bus.bus_busy !== 1'b0) ok = 1'b0;
        end
        bus.redirect_valid = 1'b0;
        check("t6_halt_hold", 32'(ok), 32'h1);

        rst_n = 1'b0;
        tick();
        check("t6_reset", {30'h0, bus.halted, bus.mem_cs}, 32'h0);
        rst_n = 1'b1;
        exp_q.push_back({16'h110C, 16'h0100});
        tick();
        check("t6_restart", {16'h0, bus.mem_addr, bus.mem_cs}, {16'h0, 15'h100, 1'b1});
        wait_valid(n);
        check("t6_restart_lat", 32'(n), 32'd3);
        tick();
        check("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
